// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mux4_rr_arbiter_if                                             |
// | Brief   : Request/grant bundle between four requesters and the arbiter.  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
interface mux4_rr_arbiter_if;
  logic [3:0] Req;
  logic [3:0] Done;
  logic [3:0] Gnt;
  logic [1:0] Sel;
  logic       Busy;
  logic       Timeout;

  modport master (
    output Req,
    output Done,
    input  Gnt,
    input  Sel,
    input  Busy,
    input  Timeout
  );

  modport slave (
    input  Req,
    input  Done,
    output Gnt,
    output Sel,
    output Busy,
    output Timeout
  );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mux4_rr_arbiter                                                |
// | Brief   : Round-robin owner of a shared 4:1 mux; optional hold timeout   |
// |           enabled by defining MUX4_ARB_TIMEOUT_EN.                       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic              Clk,
  input  logic              Rst_n,
  mux4_rr_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  generate
    if (HOLD_MAX < 2 || HOLD_MAX > 255 || (2 ** CNT_W) <= HOLD_MAX) begin : g_param_check
      $error("mux4_rr_arbiter: illegal HOLD_MAX/CNT_W combination");
    end
  endgenerate

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       r_timeout;
  logic       w_timeout_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;

  logic [7:0] w_req_dbl;
  logic [3:0] w_req_rot;
  logic [1:0] w_off;
  logic [1:0] w_winner;
  logic       w_release;
  logic       w_expire;

  // Rotate requests so the pointer position becomes bit 0, then pick the lowest set bit.
  always_comb begin
    w_req_dbl = {bus.Req, bus.Req};
    w_req_rot = w_req_dbl[r_ptr +: 4];
    if (w_req_rot[0])      w_off = 2'd0;
    else if (w_req_rot[1]) w_off = 2'd1;
    else if (w_req_rot[2]) w_off = 2'd2;
    else                   w_off = 2'd3;
    w_winner = r_ptr + w_off;
  end

  // r_sel names the owner for the whole GRANT state.
  assign w_release = bus.Done[r_sel] | ~bus.Req[r_sel];

`ifdef MUX4_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_cnt <= '0;
    end else if (r_state == S_GRANT) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= '0;
    end
  end

  assign w_expire = (r_cnt == CNT_W'(HOLD_MAX - 1)) && !w_release;
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state   <= S_IDLE;
      r_gnt     <= 4'b0000;
      r_sel     <= 2'd0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
      r_ptr     <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_sel     <= w_sel_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_sel_nxt     = r_sel;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (|bus.Req) begin
          w_gnt_nxt   = 4'b0001 << w_winner;
          w_sel_nxt   = w_winner;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_release || w_expire) begin
          w_gnt_nxt     = 4'b0000;
          w_busy_nxt    = 1'b0;
          w_ptr_nxt     = r_sel + 2'd1;
          w_timeout_nxt = w_expire;
          w_state_nxt   = S_GAP;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.Gnt     = r_gnt;
  assign bus.Sel     = r_sel;
  assign bus.Busy    = r_busy;
  assign bus.Timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_mux4_rr_arbiter                                             |
// | Brief   : Directed self-checking bench for mux4_rr_arbiter.              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mux4_rr_arbiter;

  logic Clk;
  logic Rst_n;
  int   n_chk;
  int   n_pass;

  mux4_rr_arbiter_if u_if ();

  mux4_rr_arbiter #(
    .HOLD_MAX (8),
    .CNT_W    (8)
  ) u_dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (u_if.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] gnt, input logic [1:0] sel,
                         input logic busy, input logic tmo);
    check({tag, ".gnt"}, {4'b0, u_if.Gnt}, {4'b0, gnt});
    check({tag, ".sel"}, {6'b0, u_if.Sel}, {6'b0, sel});
    check({tag, ".busy"}, {7'b0, u_if.Busy}, {7'b0, busy});
    check({tag, ".tmo"}, {7'b0, u_if.Timeout}, {7'b0, tmo});
  endtask

  initial begin
    logic [1:0] order [5];
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    n_chk    = 0;
    n_pass   = 0;
    Rst_n    = 1'b0;
    u_if.Req  = 4'b0000;
    u_if.Done = 4'b0000;
    tick();
    tick();
    chk_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    Rst_n = 1'b1;

    // Single request to source 2, released by Done.
    u_if.Req = 4'b0100;
    tick();
    chk_out("single_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
    u_if.Done = 4'b0100;
    tick();
    chk_out("single_rel", 4'b0000, 2'd2, 1'b0, 1'b0);
    u_if.Done = 4'b0000;
    u_if.Req  = 4'b0000;
    tick();

    // Reset in the middle of a grant to source 2 (pointer is 3 here).
    u_if.Req = 4'b0100;
    tick();
    chk_out("pre_rst_gnt", 4'b0100, 2'd2, 1'b1, 1'b0);
    Rst_n = 1'b0;
    tick();
    chk_out("mid_rst", 4'b0000, 2'd0, 1'b0, 1'b0);
    Rst_n = 1'b1;
    u_if.Req = 4'b1111;
    tick();
    chk_out("post_rst_gnt", 4'b0001, 2'd0, 1'b1, 1'b0);

    // Rotation with all sources requesting: 0,1,2,3,0 with two empty cycles between.
    for (int i = 0; i < 5; i++) begin
      chk_out($sformatf("rot%0d_gnt", i), 4'b0001 << order[i], order[i], 1'b1, 1'b0);
      u_if.Done = 4'b0001 << order[i];
      tick();
      chk_out($sformatf("rot%0d_gap", i), 4'b0000, order[i], 1'b0, 1'b0);
      u_if.Done = 4'b0000;
      tick();
      chk_out($sformatf("rot%0d_idle", i), 4'b0000, order[i], 1'b0, 1'b0);
      if (i == 4) u_if.Req = 4'b0000;
      tick();
    end
    chk_out("rot_end", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Pointer skip: source 0 just served, so 3 wins over 0, then 0 next.
    u_if.Req = 4'b1001;
    tick();
    chk_out("skip_gnt3", 4'b1000, 2'd3, 1'b1, 1'b0);
    u_if.Done = 4'b1000;
    tick();
    u_if.Done = 4'b0000;
    tick();
    tick();
    chk_out("skip_gnt0", 4'b0001, 2'd0, 1'b1, 1'b0);
    u_if.Req = 4'b0000;
    tick();
    chk_out("skip_rel0", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();

    // Requester drop: non-owner Done ignored, owner dropping Req releases.
    u_if.Req = 4'b0010;
    tick();
    chk_out("drop_gnt1", 4'b0010, 2'd1, 1'b1, 1'b0);
    u_if.Req  = 4'b0110;
    u_if.Done = 4'b0100;
    tick();
    chk_out("drop_nonowner", 4'b0010, 2'd1, 1'b1, 1'b0);
    u_if.Req  = 4'b0100;
    u_if.Done = 4'b0000;
    tick();
    chk_out("drop_rel", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    tick();
    chk_out("drop_wait_gnt2", 4'b0100, 2'd2, 1'b1, 1'b0);
    u_if.Req = 4'b0000;
    tick();
    tick();
    tick();

    // Stuck requester on source 1 (pointer is 3 here).
    u_if.Req = 4'b0010;
    tick();
    chk_out("hold_gnt1", 4'b0010, 2'd1, 1'b1, 1'b0);
`ifdef MUX4_ARB_TIMEOUT_EN
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk_out($sformatf("hold_cyc%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    tick();
    chk_out("tmo_pulse", 4'b0000, 2'd1, 1'b0, 1'b1);
    tick();
    chk_out("tmo_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    chk_out("tmo_regnt", 4'b0010, 2'd1, 1'b1, 1'b0);
`else
    for (int i = 2; i <= 20; i++) begin
      tick();
      chk_out($sformatf("hold_cyc%0d", i), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
`endif
    u_if.Req = 4'b0000;
    tick();
    chk_out("final_rel", 4'b0000, 2'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one `mux4to1_nand` output among four requesters. It registers a one-hot grant and the matching 2-bit mux select, and holds each grant until the owner signals completion. It sits directly in front of the 4:1 mux, so exactly one source drives the shared output at any time. An optional hold timeout stops a stuck requester from monopolising the mux.

## Interface

- `HOLD_MAX`, default 8: maximum grant length in cycles when the timeout is compiled in; legal range 2..255.
- `CNT_W`, default 8: width of the hold counter; must satisfy 2^CNT_W > HOLD_MAX.

Ports:
- `Clk`  input  1  sole clock; all state updates on the rising edge.
- `Rst_n`  input  1  reset, synchronous, active-low.
- `Req`  input  4  request per source; bit i corresponds to mux input A/B/C/D for i = 0/1/2/3.
- `Done`  input  4  per-source end-of-use strobe; only the bit of the current owner is honoured.
- `Gnt`  output  4  registered one-hot grant, or 0 when no grant is active.
- `Sel`  output  2  registered mux select, equal to the binary index of the granted source.
- `Busy`  output  1  high while any grant is active.
- `Timeout`  output  1  one-cycle pulse when a grant is force-released by the timeout.

## Operation

- State machine with three states: IDLE, GRANT, GAP.
- **IDLE**
  - No request: stay in IDLE.
  - Any `Req` bit set: pick the winner by round robin, starting at pointer `Ptr` and searching upward mod 4.
  - On that edge: `Gnt` <= one-hot(winner), `Sel` <= winner, `Busy` <= 1, go to GRANT.
- **GRANT**, with owner o
  - `Done[o]`=1 or `Req[o]`=0: release.
  - With `MUX4_ARB_TIMEOUT_EN`, a timeout expiry also releases.
  - Release: `Gnt` <= 0, `Busy` <= 0, `Ptr` <= (o+1) mod 4, go to GAP.
  - `Sel` holds its last value through GAP and IDLE; it changes only when a new grant is issued.
  - `Req`/`Done` bits of non-owners are ignored.
- **GAP**
  - Exactly one cycle, no grant; this is the settling bubble for the mux.
  - Unconditionally go to IDLE; arbitration resumes on the next edge.
- Round robin
  - After a release, the just-served source has the lowest priority.
  - `Ptr` resets to 0, so source 0 has the highest priority after reset.
- Simultaneous events
  - `Done[o]` and a timeout expiry in the same cycle count as a normal release; `Timeout` stays 0.
  - A new request arriving during GRANT or GAP waits for arbitration in IDLE.
- Reset
  - Takes priority over every other condition, including mid-grant.
  - Next edge: state IDLE, `Gnt`=0, `Sel`=0, `Busy`=0, `Timeout`=0, `Ptr`=0, hold counter 0.

## Timing

- Request to grant: `Req` sampled high in IDLE at edge k gives `Gnt`/`Sel`/`Busy` valid after edge k.
  - Minimum latency is 1 cycle from IDLE.
- Release: `Done[o]` sampled at edge k drops `Gnt` after edge k.
  - GAP occupies cycle k+1; earliest next grant is valid after edge k+2.
  - Minimum spacing between grants is 2 idle cycles: one GAP cycle plus one IDLE cycle.
- Hold counter
  - Cleared on grant entry and incremented every GRANT cycle.
  - Expiry when count == HOLD_MAX-1 and no release is pending.
  - A grant therefore lasts at most HOLD_MAX cycles.
- `Timeout` is high only during the single GAP cycle that follows a forced release.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration

- `MUX4_ARB_TIMEOUT_EN` defined:
  - Hold counter and expiry logic are present.
  - Forced release and the `Timeout` pulse behave as described above.
- Not defined:
  - No counter logic; `Timeout` is tied to 0.
  - A grant lasts until `Done[o]` or until `Req[o]` drops, with no upper bound.
  - `HOLD_MAX` and `CNT_W` are unused.

## Test plan

- **Reset mid-grant:** grant source 2, then `Rst_n`=0 for one edge -> `Gnt`=0000, `Sel`=00, `Busy`=0; next request 1111 grants source 0.
- **Single request:** `Req`=0100 from IDLE -> after one edge `Gnt`=0100, `Sel`=10, `Busy`=1; `Done`=0100 -> `Gnt`=0000 on the next edge, then GAP.
- **Rotation:** hold `Req`=1111 and pulse `Done` of the owner each grant -> grant order 0,1,2,3,0; 2 idle cycles between consecutive grants.
- **Pointer skip:** `Req`=1001 after source 0 was served -> source 3 granted (`Sel`=11); after release, source 0 is granted next.
- **Requester drop:** owner 1 deasserts `Req[1]` without `Done` -> release on the next edge; a simultaneous `Done[2]` from a non-owner has no effect.
- **Timeout:** with the macro defined and `HOLD_MAX`=8, hold `Req`=0010 and never assert `Done` -> `Gnt` high for exactly 8 cycles, then `Timeout`=1 for 1 cycle, then source 1 is re-granted after IDLE. Without the macro -> grant held indefinitely and `Timeout` stays 0.
